// File: rtl/if_id_stage_pkg.sv
// if_id_stage_pkg: shared CPU constants and fetch-hold FSM states
package if_id_stage_pkg;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP_INST = 32'h0000_0013;
    typedef enum logic {RUN, HOLD} fetch_state_e;
endpackage

// File: rtl/if_id_stage.sv
// if_id_stage: PC generation and IF/ID register with stall hold buffer and flush redirect
module if_id_stage
    import if_id_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ifs_stall,
    input  logic        ifs_flush,
    input  logic [31:0] ifs_target,
    output logic        im_ce,
    output logic [31:0] im_addr,
    input  logic [31:0] im_rdata,
    output logic [31:0] id_pc,
    output logic [31:0] id_inst,
    output logic        id_valid,
    output logic [31:0] ifs_fetch_cnt
);
    logic [31:0]  pc_q;
    logic [31:0]  id_pc_q;
    logic [31:0]  hold_inst_q;
    logic [31:0]  fetch_cnt_q;
    logic         id_valid_q;
    fetch_state_e state_q;
    fetch_state_e state_d;
    always_comb begin
        state_d = RUN;
        state_d = ifs_flush ? RUN : ifs_stall ? HOLD : RUN;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= RUN;
        else        state_q <= state_d;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q        <= RESET_PC;
            id_pc_q     <= '0;
            id_valid_q  <= 1'b0;
            hold_inst_q <= '0;
            fetch_cnt_q <= '0;
        end else if (ifs_flush) begin
            pc_q       <= {ifs_target[31:2], 2'b00};
            id_valid_q <= 1'b0;
        end else if (ifs_stall) begin
            // only the first stall cycle sees the word for id_pc on im_rdata
            if (state_q == RUN) hold_inst_q <= im_rdata;
        end else begin
            id_pc_q     <= pc_q;
            id_valid_q  <= 1'b1;
            pc_q        <= pc_q + 32'd4;
            fetch_cnt_q <= fetch_cnt_q + {31'd0, ~&fetch_cnt_q};
        end
    end
    assign im_ce         = rst_n;
    assign im_addr       = pc_q;
    assign id_pc         = id_pc_q;
    assign id_valid      = id_valid_q;
    assign ifs_fetch_cnt = fetch_cnt_q;
    assign id_inst       = !id_valid_q ? NOP_INST : (state_q == HOLD) ? hold_inst_q : im_rdata;
endmodule

// File: tb/tb_if_id_stage.sv
// tb_if_id_stage: directed scoreboard bench for if_id_stage against an ISA-level fetch model
module tb_if_id_stage;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ifs_stall = 1'b0;
    logic        ifs_flush = 1'b0;
    logic [31:0] ifs_target = '0;
    logic        im_ce;
    logic [31:0] im_addr;
    logic [31:0] im_rdata = '0;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic        id_valid;
    logic [31:0] ifs_fetch_cnt;

    int passed = 0;
    int total = 0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] cnt;
        logic        valid;
    } exp_t;
    exp_t sb[$];

    logic [31:0] m_pc = '0;
    logic [31:0] m_idpc = '0;
    logic        m_valid = 1'b0;
    logic [31:0] m_cnt = '0;

    if_id_stage dut (
        .clk(clk), .rst_n(rst_n), .ifs_stall(ifs_stall), .ifs_flush(ifs_flush),
        .ifs_target(ifs_target), .im_ce(im_ce), .im_addr(im_addr), .im_rdata(im_rdata),
        .id_pc(id_pc), .id_inst(id_inst), .id_valid(id_valid), .ifs_fetch_cnt(ifs_fetch_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word(input logic [31:0] a);
        return {2'b00, a[31:2]} + 32'h100;
    endfunction

    always @(posedge clk) im_rdata <= word(im_addr);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_pc = '0;
        m_idpc = '0;
        m_valid = 1'b0;
        m_cnt = '0;
        sb.delete();
    endtask

    task automatic step(input string tag, input logic st, input logic fl, input logic [31:0] tg);
        exp_t e;
        ifs_stall = st;
        ifs_flush = fl;
        ifs_target = tg;
        if (fl) begin
            m_pc = {tg[31:2], 2'b00};
            m_valid = 1'b0;
        end else if (!st) begin
            m_idpc = m_pc;
            m_valid = 1'b1;
            m_pc = m_pc + 32'd4;
            if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
        end
        e.addr = m_pc;
        e.pc = m_idpc;
        e.valid = m_valid;
        e.inst = m_valid ? word(m_idpc) : 32'h13;
        e.cnt = m_cnt;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk({tag, ".addr"}, im_addr, e.addr);
        chk({tag, ".valid"}, {31'd0, id_valid}, {31'd0, e.valid});
        chk({tag, ".pc"}, id_pc, e.pc);
        chk({tag, ".inst"}, id_inst, e.inst);
        chk({tag, ".cnt"}, ifs_fetch_cnt, e.cnt);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst.addr", im_addr, 32'h0);
        chk("rst.ce", {31'd0, im_ce}, 32'd0);
        chk("rst.valid", {31'd0, id_valid}, 32'd0);
        chk("rst.inst", id_inst, 32'h13);
        chk("rst.cnt", ifs_fetch_cnt, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("run.ce", {31'd0, im_ce}, 32'd1);
        model_reset();

        step("adv0", 0, 0, 0);
        chk("adv0.lit_pc", id_pc, 32'h0);
        chk("adv0.lit_inst", id_inst, 32'h100);
        step("adv1", 0, 0, 0);
        chk("adv1.lit_inst", id_inst, 32'h101);
        step("adv2", 0, 0, 0);
        chk("adv2.lit_addr", im_addr, 32'hC);

        for (int i = 0; i < 3; i++) begin
            step("stall", 1, 0, 0);
            chk("stall.lit_inst", id_inst, 32'h102);
        end
        step("release", 0, 0, 0);
        chk("release.lit_inst", id_inst, 32'h103);

        step("adv3", 0, 0, 0);
        step("flush42", 0, 1, 32'h42);
        chk("flush42.lit_addr", im_addr, 32'h40);
        step("tgt40", 0, 0, 0);
        chk("tgt40.lit_inst", id_inst, 32'h110);

        step("adv4", 0, 0, 0);
        step("pre_stall", 1, 0, 0);
        step("flush_stall80", 1, 1, 32'h80);
        step("tgt80", 0, 0, 0);
        chk("tgt80.lit_inst", id_inst, 32'h120);

        step("flush_c0", 0, 1, 32'hC0);
        step("stall_inv0", 1, 0, 0);
        step("stall_inv1", 1, 0, 0);
        step("tgtc0", 0, 0, 0);
        step("adv5", 0, 0, 0);

        step("flush_top", 0, 1, 32'hFFFF_FFFE);
        chk("flush_top.lit_addr", im_addr, 32'hFFFF_FFFC);
        step("wrap0", 0, 0, 0);
        chk("wrap0.lit_addr", im_addr, 32'h0);
        step("wrap1", 0, 0, 0);

        step("mid_stall0", 1, 0, 0);
        step("mid_stall1", 1, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async.valid", {31'd0, id_valid}, 32'd0);
        chk("async.inst", id_inst, 32'h13);
        chk("async.addr", im_addr, 32'h0);
        chk("async.cnt", ifs_fetch_cnt, 32'd0);
        chk("async.ce", {31'd0, im_ce}, 32'd0);
        @(negedge clk);
        ifs_stall = 1'b0;
        rst_n = 1'b1;
        model_reset();
        step("post_rst0", 0, 0, 0);
        chk("post_rst0.lit_inst", id_inst, 32'h100);
        step("post_rst1", 0, 0, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
